fir_mac_sequencer: RTL and testbench

Time-multiplexed FIR engine and controller. It replaces the fully parallel 5-tap FIR with one shared multiplier-accumulator, sequenced by an FSM over the taps. Samples arrive and results leave on valid/ready handshakes. Coefficients are host-programmable through a shadow bank, and a new bank is committed atomically on a sample boundary. The block sits between the sample source (ADC/test pattern) and downstream result logic, and also serves as the filter's configuration port.

---
 rtl/fir_pkg.sv | 16 +
 rtl/fir_mac.sv | 47 ++++
 rtl/fir_mac_sequencer.sv | 109 ++++++++++
 tb/tb_fir_mac_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types, default parameters and reset coefficients for the time-multiplexed FIR.
package fir_pkg;
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    localparam int NTAPS_DEF = 5;
    localparam int DW_DEF    = 8;
    localparam int CW_DEF    = 8;
    localparam int OW_DEF    = 16;

    // Taps beyond the fifth reset to zero when NTAPS is raised.
    localparam int DEF_COEF [8] = '{16, 32, 48, 16, 16, 0, 0, 0};

    function automatic int acc_width(input int dw, input int cw, input int ntaps);
        return dw + cw + $clog2(ntaps);
    endfunction
endpackage

// File: rtl/fir_mac.sv
// Shared signed multiply-accumulate with synchronous clear and saturating result view.
module fir_mac
    import fir_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF,
    parameter int OW = OW_DEF,
    parameter int AW = acc_width(DW_DEF, CW_DEF, NTAPS_DEF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] a,
    input  logic signed [CW-1:0] b,
    output logic signed [OW-1:0] y
);
    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0]    acc;

    assign prod = a * b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + AW'(prod);
    end

    generate
        if (AW > OW) begin : g_sat
            // In range when all bits from the output sign bit upward agree.
            always_comb begin
                if (&acc[AW-1:OW-1] || ~|acc[AW-1:OW-1])
                    y = acc[OW-1:0];
                else if (acc[AW-1])
                    y = {1'b1, {(OW-1){1'b0}}};
                else
                    y = {1'b0, {(OW-1){1'b1}}};
            end
        end else begin : g_ext
            assign y = OW'(acc);
        end
    endgenerate
endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR controller: sequences one shared MAC over the taps, with a shadow coefficient
// bank that is committed atomically on a sample boundary.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int DW    = DW_DEF,
    parameter int CW    = CW_DEF,
    parameter int OW    = OW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] y_out,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_addr,
    input  logic signed [CW-1:0] cfg_data,
    input  logic                 cfg_commit,
    output logic                 cfg_pending,
    output logic                 busy
);
    localparam int AW = acc_width(DW, CW, NTAPS);
    localparam int TW = $clog2(NTAPS);

    state_t                     state, state_nx;
    logic [TW-1:0]              tap;
    logic [NTAPS-1:0][DW-1:0]   dl;
    logic [NTAPS-1:0][CW-1:0]   coef_act, coef_sh;
    logic signed [DW-1:0]       mac_a;
    logic signed [CW-1:0]       mac_b;
    logic signed [OW-1:0]       y_sat, y_hold;
    logic                       accept, apply, last_tap, take, cfg_hit;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    assign last_tap  = (tap == TW'(NTAPS - 1));
    assign apply     = (state == IDLE) && cfg_pending;
    assign cfg_hit   = cfg_we && ({1'b0, cfg_addr} < 4'(NTAPS));
    assign mac_a     = dl[tap];
    assign mac_b     = coef_act[tap];
    // Last result stays visible after the handshake until the next one is presented.
    assign y_out     = out_valid ? y_sat : y_hold;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)    state_nx = MAC;
            MAC:     if (last_tap)  state_nx = OUT;
            OUT:     if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            tap    <= '0;
            dl     <= '0;
            y_hold <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                tap <= '0;
                dl  <= {dl[NTAPS-2:0], x_in};
            end else if (state == MAC) begin
                tap <= tap + 1'b1;
            end
            if (take)
                y_hold <= y_sat;
        end
    end

    // A commit arriving while one is already pending is absorbed by it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_pending <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                coef_sh[k]  <= CW'(DEF_COEF[k]);
                coef_act[k] <= CW'(DEF_COEF[k]);
            end
        end else begin
            if (cfg_hit)
                coef_sh[cfg_addr] <= cfg_data;
            if (apply)
                coef_act <= coef_sh;
            if (!cfg_pending)
                cfg_pending <= cfg_commit;
            else if (apply)
                cfg_pending <= 1'b0;
        end
    end

    fir_mac #(.DW(DW), .CW(CW), .OW(OW), .AW(AW)) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (state == MAC),
        .a   (mac_a),
        .b   (mac_b),
        .y   (y_sat)
    );
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with hand-computed expected results.
module tb_fir_mac_sequencer;
    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic signed [7:0] x_in, cfg_data;
    logic signed [15:0] y_out;
    logic              cfg_we, cfg_commit, cfg_pending, busy;
    logic [2:0]        cfg_addr;

    int checks = 0;
    int errors = 0;
    int y, lat, n, stable, na, no, cyc;
    int acc_cyc [10];
    int outs    [10];
    int exp_imp [6]  = '{16, 32, 48, 16, 16, 0};
    int exp_thr [10] = '{16, 48, 96, 112, 128, 128, 128, 128, 128, 128};
    int exp_cm  [5]  = '{32, 48, 16, 16, 0};

    always #5 clk = ~clk;

    fir_mac_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_pending(cfg_pending), .busy(busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic cfg_write(input int addr, input int data, input int commit);
        cfg_addr = 3'(addr); cfg_data = 8'(data); cfg_we = 1'b1; cfg_commit = (commit != 0);
        step();
        cfg_we = 1'b0; cfg_commit = 1'b0;
    endtask

    // Returns the result and the cycle (accept cycle = 1) in which out_valid is seen.
    task automatic send(input int x, output int yo, output int lo);
        int w;
        w = 0;
        in_valid = 1'b1; x_in = 8'(x);
        while (!in_ready && w < 100) begin step(); w++; end
        check("accept_timeout", int'(w < 100), 1);
        step();
        in_valid = 1'b0;
        lo = 1;
        while (!out_valid && lo < 100) begin step(); lo++; end
        yo = y_out;
        if (out_ready) step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; x_in = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_y_out", y_out, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", cfg_pending, 0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1);

        // impulse response
        for (int i = 0; i < 6; i++) begin
            send(i == 0 ? 1 : 0, y, lat);
            check($sformatf("imp_y%0d", i), y, exp_imp[i]);
            check($sformatf("imp_lat%0d", i), lat, 6);
        end

        // saturation
        do_reset();
        for (int k = 0; k < 5; k++) cfg_write(k, 127, k == 4 ? 1 : 0);
        check("sat_pending_set", cfg_pending, 1);
        step();
        check("sat_pending_clr", cfg_pending, 0);
        for (int i = 0; i < 5; i++) begin
            send(127, y, lat);
            if (i == 0) check("sat_pos_first", y, 16129);
        end
        check("sat_pos", y, 32767);
        for (int i = 0; i < 5; i++) send(-128, y, lat);
        check("sat_neg", y, -32768);

        // commit timing
        do_reset();
        in_valid = 1'b1; x_in = 8'sd1;
        step();
        in_valid = 1'b0;
        cfg_write(0, 1, 1);
        check("cm_pending_mac", cfg_pending, 1);
        check("cm_busy_mac", busy, 1);
        n = 0;
        while (!out_valid && n < 50) begin step(); n++; end
        check("cm_old_coef", y_out, 16);
        check("cm_pending_out", cfg_pending, 1);
        step();
        check("cm_pending_idle", cfg_pending, 1);
        check("cm_busy_idle", busy, 0);
        step();
        check("cm_pending_clr", cfg_pending, 0);
        for (int i = 0; i < 5; i++) begin
            send(0, y, lat);
            check($sformatf("cm_flush%0d", i), y, exp_cm[i]);
        end
        cfg_write(6, 99, 1);
        step();
        send(1, y, lat);
        check("cm_new_coef", y, 1);
        send(0, y, lat);
        check("cm_addr6_ignored", y, 32);

        // backpressure
        do_reset();
        out_ready = 1'b0;
        send(2, y, lat);
        check("bp_y", y, 32);
        in_valid = 1'b1; x_in = 8'sd5;
        stable = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (y_out !== 16'sd32 || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 0;
        end
        check("bp_stable", stable, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("bp_rel_valid", out_valid, 0);
        check("bp_rel_busy", busy, 0);
        check("bp_rel_y_hold", y_out, 32);
        step();
        check("bp_idle", busy, 0);
        send(0, y, lat);
        check("bp_not_consumed", y, 64);

        // reset mid-MAC
        do_reset();
        cfg_write(0, 7, 1);
        step();
        send(1, y, lat);
        check("rm_committed", y, 7);
        in_valid = 1'b1; x_in = 8'sd3;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("rm_busy_before", busy, 1);
        check("rm_y_before", y_out, 7);
        rst = 1'b1;
        #1;
        check("rm_out_valid", out_valid, 0);
        check("rm_y_out", y_out, 0);
        check("rm_busy", busy, 0);
        check("rm_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        #1;
        send(1, y, lat);
        check("rm_default_coef", y, 16);
        send(0, y, lat);
        check("rm_dl_cleared", y, 32);

        // throughput
        do_reset();
        in_valid = 1'b1; x_in = 8'sd1;
        na = 0; no = 0; cyc = 0;
        while ((na < 10 || no < 10) && cyc < 300) begin
            if (in_valid && in_ready) begin acc_cyc[na] = cyc; na++; end
            if (out_valid && out_ready && no < 10) begin outs[no] = y_out; no++; end
            step();
            cyc++;
            if (na == 10) in_valid = 1'b0;
        end
        check("thr_accepts", na, 10);
        check("thr_outputs", no, 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("thr_y%0d", i), outs[i], exp_thr[i]);
            if (i > 0) check($sformatf("thr_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
